// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared widths, constants and FSM encoding for the e^x sequencer
package exp_pkg;

  localparam int INT_W  = 3;
  localparam int FRAC_W = 23;
  localparam int W      = INT_W + FRAC_W;

  localparam logic [W-1:0] ONE = 26'h0800000;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] SER_A  = 3'd2;
  localparam logic [2:0] SER_B  = 3'd3;
  localparam logic [2:0] FINAL  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // 1/k in Q3.23, truncated toward zero; index 0 is never used by the series
  function automatic logic [W-1:0] recip(input logic [2:0] k);
    case (k)
      3'd1:    recip = 26'h0800000;
      3'd2:    recip = 26'h0400000;
      3'd3:    recip = 26'h02AAAAA;
      3'd4:    recip = 26'h0200000;
      3'd5:    recip = 26'h0199999;
      3'd6:    recip = 26'h0155555;
      3'd7:    recip = 26'h0124924;
      default: recip = 26'h0000000;
    endcase
  endfunction

endpackage

// File: rtl/exp_seq_ctrl_if.sv
// rtl/exp_seq_ctrl_if.sv - operand, LUT and result handshake bundle of the e^x sequencer
interface exp_seq_ctrl_if import exp_pkg::*; #(
  parameter int NUM_OF_INT  = INT_W,
  parameter int NUM_OF_FRAC = FRAC_W
);
  logic                   IN_valid;
  logic                   IN_ready;
  logic [NUM_OF_INT-1:0]  IN_int;
  logic [NUM_OF_FRAC-1:0] IN_frac;
  logic [NUM_OF_INT-1:0]  LUT_IN_int;
  logic [NUM_OF_FRAC-1:0] LUT_IN_frac;
  logic [NUM_OF_INT-1:0]  LUT_OUT_int;
  logic [NUM_OF_FRAC-1:0] LUT_OUT_frac;
  logic [NUM_OF_INT-1:0]  LUT_a_int;
  logic [NUM_OF_FRAC-1:0] LUT_a_frac;
  logic                   OUT_valid;
  logic                   OUT_ready;
  logic [NUM_OF_INT-1:0]  OUT_int;
  logic [NUM_OF_FRAC-1:0] OUT_frac;
  logic                   OUT_ovf;

  // master is the surrounding system (producer, LUT, consumer); slave is the sequencer
  modport master (
    output IN_valid, IN_int, IN_frac, LUT_OUT_int, LUT_OUT_frac, LUT_a_int, LUT_a_frac, OUT_ready,
    input  IN_ready, LUT_IN_int, LUT_IN_frac, OUT_valid, OUT_int, OUT_frac, OUT_ovf
  );

  modport slave (
    input  IN_valid, IN_int, IN_frac, LUT_OUT_int, LUT_OUT_frac, LUT_a_int, LUT_a_frac, OUT_ready,
    output IN_ready, LUT_IN_int, LUT_IN_frac, OUT_valid, OUT_int, OUT_frac, OUT_ovf
  );
endinterface

// File: rtl/exp_mul_q3_23.sv
// rtl/exp_mul_q3_23.sv - unsigned fixed-point multiply with truncation and saturation
module exp_mul_q3_23 import exp_pkg::*; #(
  parameter  int NUM_OF_INT  = INT_W,
  parameter  int NUM_OF_FRAC = FRAC_W,
  localparam int MW          = NUM_OF_INT + NUM_OF_FRAC
) (
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic [MW-1:0] p
);

  logic [2*MW-1:0] prod;
  logic [2*MW-1:0] shifted;

  assign prod    = {{MW{1'b0}}, a} * {{MW{1'b0}}, b};
  assign shifted = prod >> NUM_OF_FRAC;

  // anything left above the integer field means the result does not fit
  assign p = (|shifted[2*MW-1:MW]) ? {MW{1'b1}} : shifted[MW-1:0];

endmodule

// File: rtl/exp_seq_ctrl.sv
// rtl/exp_seq_ctrl.sv - multi-cycle e^x sequencer: coarse LUT times Horner Taylor series
module exp_seq_ctrl import exp_pkg::*; #(
  parameter int NUM_OF_INT  = INT_W,
  parameter int NUM_OF_FRAC = FRAC_W,
  parameter int N_TERMS     = 4
) (
  input logic          CLK,
  input logic          RST_N,
  exp_seq_ctrl_if.slave bus
);

  localparam int            XW    = NUM_OF_INT + NUM_OF_FRAC;
  localparam logic [XW-1:0] ONE_Q = XW'(1) << NUM_OF_FRAC;

  logic [2:0]    state;
  logic [XW-1:0] x_reg;
  logic [XW-1:0] ea_reg;
  logic [XW-1:0] d_reg;
  logic [XW-1:0] acc;
  logic [XW-1:0] t_reg;
  logic [2:0]    k;
  logic          ovf_reg;
  logic [XW-1:0] out_reg;
  logic          out_valid;
  logic          out_ovf;

  logic [XW-1:0] mul_a;
  logic [XW-1:0] mul_b;
  logic [XW-1:0] mul_p;

  assign bus.IN_ready    = (state == IDLE);
  assign bus.LUT_IN_int  = x_reg[XW-1:NUM_OF_FRAC];
  assign bus.LUT_IN_frac = x_reg[NUM_OF_FRAC-1:0];
  assign bus.OUT_valid   = out_valid;
  assign bus.OUT_int     = out_reg[XW-1:NUM_OF_FRAC];
  assign bus.OUT_frac    = out_reg[NUM_OF_FRAC-1:0];
  assign bus.OUT_ovf     = out_ovf;

  // one multiplier shared by the series steps and the final e^a * e^d product
  always_comb begin
    mul_a = acc;
    mul_b = XW'(recip(k));
    case (state)
      SER_B: begin
        mul_a = t_reg;
        mul_b = d_reg;
      end
      FINAL: begin
        mul_a = ea_reg;
        mul_b = acc;
      end
      default: ;
    endcase
  end

  exp_mul_q3_23 #(
    .NUM_OF_INT  (NUM_OF_INT),
    .NUM_OF_FRAC (NUM_OF_FRAC)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      x_reg     <= '0;
      ea_reg    <= '0;
      d_reg     <= '0;
      acc       <= '0;
      t_reg     <= '0;
      k         <= '0;
      ovf_reg   <= 1'b0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.IN_valid) begin
            x_reg <= {bus.IN_int, bus.IN_frac};
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          ea_reg  <= {bus.LUT_OUT_int, bus.LUT_OUT_frac};
          d_reg   <= x_reg - {bus.LUT_a_int, bus.LUT_a_frac};
          acc     <= ONE_Q;
          k       <= 3'(N_TERMS);
          ovf_reg <= (x_reg[XW-1:NUM_OF_FRAC] != '0);
          state   <= SER_A;
        end
        SER_A: begin
          t_reg <= mul_p;
          state <= SER_B;
        end
        SER_B: begin
          acc <= ONE_Q + mul_p;
          if (k == 3'd1) begin
            state <= FINAL;
          end else begin
            k     <= k - 3'd1;
            state <= SER_A;
          end
        end
        FINAL: begin
          // an out-of-range operand still walks the series so latency stays fixed
          out_reg   <= ovf_reg ? {XW{1'b1}} : mul_p;
          out_ovf   <= ovf_reg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.OUT_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// tb/tb_exp_seq_ctrl.sv - randomized self-checking bench for exp_seq_ctrl against a real-valued e^x model
module tb_exp_seq_ctrl;

  logic clk;
  logic rst_n;

  exp_seq_ctrl_if bus ();

  exp_seq_ctrl #(.NUM_OF_INT(3), .NUM_OF_FRAC(23), .N_TERMS(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [25:0] lut_e [256];
  logic [7:0]  lut_idx;

  // coarse LUT: a keeps the top 8 fraction bits, e^a truncated to Q3.23
  assign lut_idx = bus.LUT_IN_frac[22:15];
  always_comb begin
    bus.LUT_a_int    = bus.LUT_IN_int;
    bus.LUT_a_frac   = {lut_idx, 15'd0};
    bus.LUT_OUT_int  = lut_e[lut_idx][25:23];
    bus.LUT_OUT_frac = lut_e[lut_idx][22:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [25:0] ref_exp(input logic [25:0] x);
    if (x[25:23] != 3'd0) return '1;
    return 26'($rtoi($exp(real'(x) / 8388608.0) * 8388608.0 + 0.5));
  endfunction

  // exact for x = 0 and out-of-range, otherwise within 8 LSB of the true value
  function automatic logic [31:0] snap(input logic [25:0] x, input logic [25:0] got, input logic [25:0] refv);
    int diff;
    int tol;
    tol  = (x == 26'd0 || x[25:23] != 3'd0) ? 0 : 8;
    diff = int'(got) - int'(refv);
    if (diff < 0) diff = -diff;
    return (diff <= tol) ? {6'd0, refv} : {6'd0, got};
  endfunction

  task automatic run_op(input logic [2:0] xi, input logic [22:0] xf, input int hold);
    int          cyc;
    logic        busy_ok;
    logic        stable_ok;
    logic [25:0] x;
    logic [25:0] got;
    logic        got_ovf;
    x = {xi, xf};
    check("in_ready_idle", {31'd0, bus.IN_ready}, 32'd1);
    bus.IN_valid  = 1'b1;
    bus.IN_int    = xi;
    bus.IN_frac   = xf;
    bus.OUT_ready = (hold == 0);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.IN_valid = 1'($urandom_range(0, 1));
    bus.IN_int   = 3'($urandom);
    bus.IN_frac  = 23'($urandom);
    busy_ok = 1'b1;
    while (!bus.OUT_valid && cyc < 40) begin
      if (bus.IN_ready) busy_ok = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    bus.IN_valid = 1'b0;
    check("latency", cyc, 32'd11);
    check("busy_in_ready_low", {31'd0, busy_ok}, 32'd1);
    got     = {bus.OUT_int, bus.OUT_frac};
    got_ovf = bus.OUT_ovf;
    check("result", snap(x, got, ref_exp(x)), {6'd0, ref_exp(x)});
    check("ovf", {31'd0, got_ovf}, {31'd0, (xi != 3'd0)});
    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.OUT_valid || bus.IN_ready || {bus.OUT_int, bus.OUT_frac} != got || bus.OUT_ovf != got_ovf)
        stable_ok = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", {31'd0, stable_ok}, 32'd1);
    bus.OUT_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", {31'd0, bus.OUT_valid}, 32'd0);
    check("in_ready_after", {31'd0, bus.IN_ready}, 32'd1);
    check("out_retained", {5'd0, bus.OUT_ovf, bus.OUT_int, bus.OUT_frac}, {5'd0, got_ovf, got});
    bus.OUT_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic quiet_ok;
    for (int i = 0; i < 256; i++)
      lut_e[i] = 26'($rtoi($floor($exp(real'(i) / 256.0) * 8388608.0)));
    rst_n        = 1'b0;
    bus.IN_valid  = 1'b0;
    bus.IN_int    = '0;
    bus.IN_frac   = '0;
    bus.OUT_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.OUT_valid}, 32'd0);
    check("rst_out_value", {5'd0, bus.OUT_ovf, bus.OUT_int, bus.OUT_frac}, 32'd0);
    check("rst_in_ready", {31'd0, bus.IN_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 23'h000000, 0);
    check("x0_exact", {6'd0, bus.OUT_int, bus.OUT_frac}, 32'h0800000);
    run_op(3'd0, 23'h400000, 0);
    run_op(3'd0, 23'h0CCCCD, 0);
    run_op(3'd2, 23'h000000, 0);
    check("ovf_all_ones", {6'd0, bus.OUT_int, bus.OUT_frac}, 32'h3FFFFFF);
    run_op(3'd0, 23'($urandom), 5);
    run_op(3'd0, 23'($urandom), 0);

    // reset while the series is running (third edge after accept lands in SER_B)
    bus.IN_valid = 1'b1;
    bus.IN_int   = 3'd0;
    bus.IN_frac  = 23'h59999A;
    bus.OUT_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.IN_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus.OUT_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.IN_ready}, 32'd1);
    check("midrst_out_clear", {5'd0, bus.OUT_ovf, bus.OUT_int, bus.OUT_frac}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.OUT_valid || !bus.IN_ready) quiet_ok = 1'b0;
    end
    check("no_stale_result", {31'd0, quiet_ok}, 32'd1);
    run_op(3'd0, 23'h200000, 0);

    for (int n = 0; n < 16; n++) begin
      logic [2:0] xi;
      xi = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      run_op(xi, 23'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
